sync: RTL and testbench



---
 rtl/sync_tff.sv | 30 +++
 rtl/sync.sv | 53 +++++
 tb/tb_sync.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sync_tff.sv
// sync_tff: single T flip-flop with asynchronous active-high clear.
//   clock : rising-edge clock
//   clear : asynchronous clear, forces q to 0 while high
//   t     : toggle enable, q inverts on a rising edge when 1
//   q     : registered state
module sync_tff (
    input  logic clock,
    input  logic clear,
    input  logic t,
    output logic q
);

    logic q_d;
    logic q_q;

    always_comb begin
        q_d = q_q ^ t;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sync.sv
// sync: 3-bit synchronous binary counter built from three T flip-flops.
//   Y0..Y2 : registered count bits, Y0 is the LSB
//   clock  : rising-edge clock shared by all bits
//   clear  : asynchronous active-high clear, count forced to 000
//   enable : 1 = step on the rising edge, 0 = hold
//   DOWN   : 0 = count up, 1 = count down (fixed at elaboration)
// Port order is relied on by positional instantiations; keep it as is.
module sync #(
    parameter int DOWN = 0
) (
    output logic Y0,
    output logic Y1,
    output logic Y2,
    input  logic clock,
    input  logic clear,
    input  logic enable
);

    localparam int WIDTH = 3;

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] t;

    // A bit toggles when every lower bit is at its carry value:
    // all ones when counting up, all zeros when counting down.
    generate
        if (DOWN != 0) begin : g_down
            assign t[0] = enable;
            assign t[1] = enable & ~q[0];
            assign t[2] = enable & ~q[0] & ~q[1];
        end else begin : g_up
            assign t[0] = enable;
            assign t[1] = enable & q[0];
            assign t[2] = enable & q[0] & q[1];
        end
    endgenerate

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            sync_tff u_tff (
                .clock (clock),
                .clear (clear),
                .t     (t[i]),
                .q     (q[i])
            );
        end
    endgenerate

    assign Y0 = q[0];
    assign Y1 = q[1];
    assign Y2 = q[2];

endmodule

// File: tb/tb_sync.sv
`timescale 1ns/1ps
module tb_sync;

    logic clk;
    logic clear;
    logic enable;
    logic u_y0, u_y1, u_y2;
    logic d_y0, d_y1, d_y2;

    sync #(.DOWN(0)) dut_up (
        .Y0(u_y0), .Y1(u_y1), .Y2(u_y2),
        .clock(clk), .clear(clear), .enable(enable)
    );

    sync #(.DOWN(1)) dut_dn (
        .Y0(d_y0), .Y1(d_y1), .Y2(d_y2),
        .clock(clk), .clear(clear), .enable(enable)
    );

    // Rising edges at t = 2, 4, 6, ...
    initial clk = 1'b1;
    always #1 clk = ~clk;

    typedef struct {
        logic       en;
        logic [2:0] up_exp;
        logic [2:0] dn_exp;
    } vec_t;

    typedef struct {
        logic [2:0] up_exp;
        logic [2:0] dn_exp;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[16];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model for the hand-written sequences.
    logic [2:0] m_up;
    logic [2:0] m_dn;

    task automatic check(input string name);
        exp_t e;
        logic [2:0] au, ad;
        au = {u_y2, u_y1, u_y0};
        ad = {d_y2, d_y1, d_y0};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty, up=%b dn=%b", name, au, ad);
        end else begin
            e = exp_q.pop_front();
            if (au !== e.up_exp || ad !== e.dn_exp) begin
                n_err++;
                $display("FAIL %s: up got %b want %b, dn got %b want %b",
                         name, au, e.up_exp, ad, e.dn_exp);
            end
        end
    endtask

    task automatic push(input logic [2:0] eu, input logic [2:0] ed);
        exp_t e;
        e.up_exp = eu;
        e.dn_exp = ed;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; drives enable, waits one rising edge, checks.
    task automatic step(input logic en, input string name);
        enable = en;
        if (clear) begin
            m_up = 3'd0;
            m_dn = 3'd0;
        end else if (en) begin
            m_up = m_up + 3'd1;
            m_dn = m_dn - 3'd1;
        end
        push(m_up, m_dn);
        @(posedge clk);
        @(negedge clk);
        check(name);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1'b1, 3'b001, 3'b111};
        vecs[1]  = '{1'b1, 3'b010, 3'b110};
        vecs[2]  = '{1'b1, 3'b011, 3'b101};
        vecs[3]  = '{1'b1, 3'b100, 3'b100};
        vecs[4]  = '{1'b1, 3'b101, 3'b011};
        vecs[5]  = '{1'b1, 3'b110, 3'b010};
        vecs[6]  = '{1'b1, 3'b111, 3'b001};
        vecs[7]  = '{1'b1, 3'b000, 3'b000};
        vecs[8]  = '{1'b1, 3'b001, 3'b111};
        vecs[9]  = '{1'b1, 3'b010, 3'b110};
        vecs[10] = '{1'b1, 3'b011, 3'b101};
        vecs[11] = '{1'b1, 3'b100, 3'b100};
        vecs[12] = '{1'b1, 3'b101, 3'b011};
        vecs[13] = '{1'b1, 3'b110, 3'b010};
        vecs[14] = '{1'b1, 3'b111, 3'b001};
        vecs[15] = '{1'b0, 3'b111, 3'b001};

        clear  = 1'b1;
        enable = 1'b1;
        #0.5;
        push(3'b000, 3'b000);
        check("reset");

        // t = 1: release clear, then walk the vector table.
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < 16; i++) begin
            enable = vecs[i].en;
            push(vecs[i].up_exp, vecs[i].dn_exp);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("table[%0d]", i));
        end

        // Hold: count to 101 / 011, drop enable for 3 edges, resume.
        clear = 1'b1;
        #0.5;
        push(3'b000, 3'b000);
        check("clear_async_a");
        @(negedge clk);
        clear = 1'b0;
        m_up = 3'd0;
        m_dn = 3'd0;
        for (int i = 0; i < 5; i++) step(1'b1, "count_to_5");
        for (int i = 0; i < 3; i++) step(1'b0, "hold");
        step(1'b1, "resume_after_hold");

        // Mid-run clear between edges at 110.
        #0.5;
        clear = 1'b1;
        #0.2;
        push(3'b000, 3'b000);
        check("midrun_clear_async");
        @(negedge clk);
        for (int i = 0; i < 2; i++) step(1'b1, "held_in_clear");
        clear = 1'b0;
        step(1'b1, "first_after_release");

        // Count to 011 (up), then clear coincident with the rising edge.
        step(1'b1, "pre_coinc_a");
        step(1'b1, "pre_coinc_b");
        @(posedge clk);
        clear = 1'b1;
        @(negedge clk);
        push(3'b000, 3'b000);
        check("clear_coincident_edge");

        // Idle out of reset for 10 edges.
        clear = 1'b0;
        m_up = 3'd0;
        m_dn = 3'd0;
        for (int i = 0; i < 10; i++) step(1'b0, "idle_after_release");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
